// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and word helpers for the
// decryption-side key schedule.
package aes_pkg;

  localparam int unsigned AES128_NR = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    SERVE  = 2'd2
  } fsm_t;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_byte(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_byte(w[31:24]), sbox_byte(w[23:16]),
            sbox_byte(w[15:8]),  sbox_byte(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational single-byte forward S-box lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] sub
);

  assign sub = sbox_byte(data);

endmodule

// File: rtl/inv_add_round_key_seq.sv
// AES-128 decryption AddRoundKey stage: expands the cipher key forward to
// round 10, then applies round keys 10..0 while stepping the schedule back.
module inv_add_round_key_seq
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic [3:0]   round_out
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  fsm_t         fsm;
  logic [127:0] key;
  logic [127:0] k10;
  logic [3:0]   rnd;
  logic [3:0]   cnt;

  logic [31:0]  w0, w1, w2, w3, w3p;
  logic [31:0]  sw_in, sw_out, nw0;
  logic [7:0]   rc;
  logic [127:0] key_fwd, key_back;
  logic         accept;

  assign {w0, w1, w2, w3} = key;

  // One SubWord datapath serves both directions: forward rounds use w3,
  // inverse steps use the recovered previous-round w3.
  always_comb begin
    w3p      = w3 ^ w2;
    sw_in    = rot_word((fsm == EXPAND) ? w3 : w3p);
    rc       = rcon((fsm == EXPAND) ? cnt : rnd);
    nw0      = w0 ^ sw_out ^ {rc, 24'h000000};
    key_fwd  = {nw0, w1 ^ nw0, w2 ^ w1 ^ nw0, w3 ^ w2 ^ w1 ^ nw0};
    key_back = {nw0, w1 ^ w0, w2 ^ w1, w3p};
  end

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .data (sw_in[8*i +: 8]),
      .sub  (sw_out[8*i +: 8])
    );
  end

  // key_ready is only ever set in SERVE, so it gates acceptance directly.
  assign in_ready = key_ready && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      key       <= '0;
      k10       <= '0;
      rnd       <= '0;
      cnt       <= '0;
      key_ready <= 1'b0;
      out_valid <= 1'b0;
      state_out <= '0;
      round_out <= '0;
    end else if (key_load) begin
      key       <= key_in;
      cnt       <= 4'd1;
      fsm       <= EXPAND;
      key_ready <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (fsm)
        EXPAND: begin
          key <= key_fwd;
          if (cnt == LAST_ROUND) begin
            k10       <= key_fwd;
            rnd       <= LAST_ROUND;
            key_ready <= 1'b1;
            fsm       <= SERVE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SERVE: begin
          if (accept) begin
            state_out <= state_in ^ key;
            round_out <= rnd;
            out_valid <= 1'b1;
            if (rnd != 4'd0) begin
              key <= key_back;
              rnd <= rnd - 4'd1;
            end else begin
              key <= k10;
              rnd <= LAST_ROUND;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_add_round_key_seq.sv
// Directed bench for inv_add_round_key_seq with a queue-based scoreboard of
// expected (state, round) pairs checked against known FIPS-197 round keys.
module tb_inv_add_round_key_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [127:0] key_in;
  logic         key_ready;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic [3:0]   round_out;

  always #5 clk = ~clk;

  inv_add_round_key_seq #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_load  (key_load),
    .key_in    (key_in),
    .key_ready (key_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .round_out (round_out)
  );

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   rnd;
  } exp_t;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  exp_t         sb[$];
  logic [127:0] rk_c1 [11];
  logic [127:0] rk [11];
  int unsigned  model_rnd;
  int           n_cmp  = 0;
  int           n_fail = 0;
  bit           accepted;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Samples at the falling edge, then advances past the next rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    accepted = 1'b0;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 128'(out_valid), 128'd0);
      end else begin
        e = sb.pop_front();
        check("state_out", state_out, e.data);
        check("round_out", 128'(round_out), 128'(e.rnd));
      end
    end
    if (!rst && !key_load && in_valid && in_ready) begin
      e.data = state_in ^ rk[model_rnd];
      e.rnd  = 4'(model_rnd);
      sb.push_back(e);
      model_rnd = (model_rnd == 0) ? 10 : model_rnd - 1;
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k, input bit use_a1);
    int  n;
    bit  early_ready;
    if (use_a1) begin
      for (int i = 0; i < 11; i++) rk[i] = '0;
      rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    end else begin
      for (int i = 0; i < 11; i++) rk[i] = rk_c1[i];
    end
    in_valid = 1'b0;
    key_in   = k;
    key_load = 1'b1;
    cycle();
    key_load  = 1'b0;
    model_rnd = 10;
    check("out_valid_after_load", 128'(out_valid), 128'd0);
    n = 0;
    early_ready = 1'b0;
    while (!key_ready && n < 30) begin
      if (in_ready) early_ready = 1'b1;
      cycle();
      n++;
    end
    check("key_ready_latency", 128'(n), 128'd10);
    check("in_ready_during_expand", 128'(early_ready), 128'd0);
  endtask

  task automatic send_one(input logic [127:0] s);
    int n;
    in_valid = 1'b1;
    state_in = s;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!accepted && n < 30);
    in_valid = 1'b0;
    check("accept_timeout", 128'(accepted), 128'd1);
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 30) begin
      cycle();
      n++;
    end
    check("drain_empty", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    logic [127:0] held;
    int           n;
    bit           bad;

    rk_c1[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rk_c1[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rk_c1[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rk_c1[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rk_c1[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rk_c1[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rk_c1[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rk_c1[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rk_c1[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rk_c1[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rk_c1[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    for (int i = 0; i < 11; i++) rk[i] = rk_c1[i];
    model_rnd = 10;

    rst = 1'b1; key_load = 1'b0; key_in = '0;
    in_valid = 1'b0; state_in = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_key_ready", 128'(key_ready), 128'd0);
    check("rst_in_ready",  128'(in_ready),  128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_state_out", state_out, 128'd0);
    check("rst_round_out", 128'(round_out), 128'd0);

    // in_valid while idle must be ignored
    rst = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (3) cycle();
    check("idle_in_ready", 128'(in_ready), 128'd0);
    check("idle_out_valid", 128'(out_valid), 128'd0);
    in_valid = 1'b0;

    // C.1 key: twelve zero states covers rounds 10..0 and the wrap to 10
    load_key(C1_KEY, 1'b0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = '0;
    n = 0;
    for (int i = 0; i < 40 && n < 12; i++) begin
      cycle();
      if (accepted) n++;
    end
    check("stream_accepts", 128'(n), 128'd12);
    drain();

    // A.1 key with an all-ones state
    load_key(A1_KEY, 1'b1);
    send_one('1);
    drain();

    // Backpressure: one transfer, then hold for five cycles
    load_key(C1_KEY, 1'b0);
    out_ready = 1'b0;
    send_one(128'h00112233445566778899aabbccddeeff);
    held = state_out;
    in_valid = 1'b1;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (in_ready || !out_valid || state_out !== held || round_out !== 4'd10) bad = 1'b1;
      cycle();
    end
    check("hold_stable", 128'(bad), 128'd0);
    check("hold_state_out", state_out, held);
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 128'(in_ready), 128'd1);
    cycle();
    check("release_accept", 128'(accepted), 128'd1);
    drain();

    // key_load after three blocks restarts with the A.1 schedule
    in_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      state_in = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      if (accepted) n++;
    end
    check("pre_reload_accepts", 128'(n), 128'd3);
    load_key(A1_KEY, 1'b1);
    check("reload_sb_empty", 128'(sb.size()), 128'd0);
    send_one(128'h0123456789abcdeffedcba9876543210);
    drain();

    // Asynchronous reset while an output is held
    out_ready = 1'b0;
    send_one(128'hdeadbeefcafef00d0123456789abcdef);
    check("pre_reset_out_valid", 128'(out_valid), 128'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_out_valid", 128'(out_valid), 128'd0);
    check("async_state_out", state_out, 128'd0);
    check("async_round_out", 128'(round_out), 128'd0);
    check("async_key_ready", 128'(key_ready), 128'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (in_ready || out_valid) bad = 1'b1;
      cycle();
    end
    check("post_reset_idle", 128'(bad), 128'd0);
    load_key(C1_KEY, 1'b0);
    check("post_reload_in_ready", 128'(in_ready), 128'd1);
    send_one('0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
